jtcop_obj_dma: RTL and testbench

- Object-table provider for the sprite draw engine; the responder side of its tbl_addr/tbl_dout read interface.
- Holds the CPU-visible object RAM: 1024 words, 256 objects × 4 words.
- On a CPU DMA trigger, copies the whole object RAM into the back bank of a double-buffered table.
- Swaps banks at the next vertical-blank start, so the draw engine always parses a stable, complete frame of objects.

---
 rtl/jtcop_obj_dma.sv | 124 ++++++++++++
 tb/tb_jtcop_obj_dma.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_dma.sv
// Object table provider: CPU-visible object RAM plus a double-buffered table
// that is refreshed by DMA and swapped at the start of vertical blank.
module jtcop_obj_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic [1:0]    cpu_dsn,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_din,
    input  logic          dma_trig,
    output logic          dma_busy,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] tbl_dout,
    output logic          bank
);

    localparam int HB = DW / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_PEND
    } state_t;

    logic [DW-1:0] obj_ram [0:(2**AW)-1];
    logic [DW-1:0] tbl_mem [0:(2**(AW+1))-1];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          lvbl_q;
    logic          rd_vld;
    logic          wr_vld_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] dma_data_q;
    logic [DW-1:0] cpu_din_q;
    logic [DW-1:0] tbl_dout_q;
    logic          vb_start;

    assign vb_start = lvbl_q & ~LVBL;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rd_vld  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_trig) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end
            end
            ST_COPY: begin
                rd_vld = 1'b1;
                if (dma_trig) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    state_d = ST_PEND;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_PEND: begin
                // The swap waits for the last write to drain so the new front
                // bank is complete and never written after it goes live.
                if (dma_trig) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end else if (vb_start && !wr_vld_q) begin
                    bank_d  = ~bank_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bank_q     <= 1'b0;
            lvbl_q     <= 1'b1;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            cpu_din_q  <= '0;
            tbl_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            lvbl_q     <= LVBL;
            wr_vld_q   <= rd_vld;
            wr_addr_q  <= cnt_q;
            cpu_din_q  <= obj_ram[cpu_addr];
            tbl_dout_q <= tbl_mem[{bank_q, tbl_addr}];
        end
    end

    // NOTE: RAM arrays and the DMA data pipe are deliberately left out of
    // reset; clearing storage would need a sweep and is not wanted.
    always_ff @(posedge clk) begin
        dma_data_q <= obj_ram[cnt_q];
        if (cpu_we && !cpu_dsn[1]) obj_ram[cpu_addr][DW-1:HB] <= cpu_dout[DW-1:HB];
        if (cpu_we && !cpu_dsn[0]) obj_ram[cpu_addr][HB-1:0]  <= cpu_dout[HB-1:0];
        if (wr_vld_q) tbl_mem[{~bank_q, wr_addr_q}] <= dma_data_q;
    end

    assign cpu_din  = cpu_din_q;
    assign tbl_dout = tbl_dout_q;
    assign bank     = bank_q;
    assign dma_busy = (state_q == ST_COPY) | wr_vld_q;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed bench for jtcop_obj_dma: byte strobes, copy length, retrigger,
// vblank swap gating and pending-swap cancellation.
module tb_jtcop_obj_dma;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          LVBL;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [1:0]    cpu_dsn;
    logic          cpu_we;
    logic [DW-1:0] cpu_din;
    logic          dma_trig;
    logic          dma_busy;
    logic [AW-1:0] tbl_addr;
    logic [DW-1:0] tbl_dout;
    logic          bank;

    int n_checks = 0;
    int n_errors = 0;

    jtcop_obj_dma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_dsn  (cpu_dsn),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .dma_trig (dma_trig),
        .dma_busy (dma_busy),
        .tbl_addr (tbl_addr),
        .tbl_dout (tbl_dout),
        .bank     (bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // 0: xor pattern, 1: linear pattern, 2: linear with word 10 forced,
    // 3: pattern 2 with word 0 forced.
    function automatic logic [DW-1:0] pat(input int sel, input int i);
        logic [DW-1:0] w;
        if (sel == 0) w = DW'(i) ^ 16'h5A5A;
        else          w = DW'(i * 7 + 3);
        if (sel >= 2 && i == 10) w = 16'hFFFF;
        if (sel == 3 && i == 0)  w = 16'h0001;
        return w;
    endfunction

    task automatic cpu_write(input int a, input logic [DW-1:0] d, input logic [1:0] dsn);
        cpu_addr = AW'(a);
        cpu_dout = d;
        cpu_dsn  = dsn;
        cpu_we   = 1'b1;
        tick();
        cpu_we   = 1'b0;
        cpu_dsn  = 2'b11;
    endtask

    task automatic fill(input int sel);
        for (int i = 0; i < NW; i++) cpu_write(i, pat(sel, i), 2'b00);
    endtask

    task automatic trig_pulse();
        dma_trig = 1'b1;
        tick();
        dma_trig = 1'b0;
    endtask

    // Counts busy cycles from the current one; lvbl_at > 0 drops LVBL then.
    task automatic wait_busy(input string tag, input int lvbl_at);
        int n = 0;
        while (dma_busy && n < 3000) begin
            n++;
            if (n == lvbl_at) LVBL = 1'b0;
            tick();
        end
        check(tag, n, 1025);
    endtask

    task automatic vblank();
        LVBL = 1'b0;
        tick_n(2);
        LVBL = 1'b1;
        tick();
    endtask

    task automatic sweep(input string tag, input int sel);
        int bad = 0;
        for (int i = 0; i < NW; i++) begin
            tbl_addr = AW'(i);
            tick();
            if (tbl_dout !== pat(sel, i)) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        LVBL     = 1'b1;
        cpu_addr = '0;
        cpu_dout = '0;
        cpu_dsn  = 2'b11;
        cpu_we   = 1'b0;
        dma_trig = 1'b1;
        tbl_addr = '0;
        #2;
        tick_n(4);
        check("rst_bank", bank, 0);
        check("rst_busy", dma_busy, 0);
        check("rst_tbl_dout", tbl_dout, 0);
        check("rst_cpu_din", cpu_din, 0);
        rst      = 1'b1;
        dma_trig = 1'b0;
        tick();

        // Byte strobes and read-before-write on the CPU port
        cpu_write(5, 16'h1234, 2'b00);
        cpu_write(5, 16'hABCD, 2'b01);
        cpu_addr = 10'd5;
        tick();
        check("byte_strobe", cpu_din, 16'hAB34);
        cpu_write(5, 16'h0000, 2'b00);
        check("cpu_rbw_old", cpu_din, 16'hAB34);
        tick();
        check("cpu_rbw_new", cpu_din, 16'h0000);

        // Basic copy into bank 1, swap on vblank start
        fill(0);
        trig_pulse();
        wait_busy("copy0_busy_len", 0);
        tick_n(20);
        check("copy0_bank_hold", bank, 0);
        vblank();
        check("copy0_bank_swap", bank, 1);
        sweep("copy0_sweep", 0);

        // Retrigger at copy cycle 300 after changing word 10; LVBL falls mid-copy
        fill(1);
        trig_pulse();
        tick_n(298);
        cpu_write(10, 16'hFFFF, 2'b00);
        trig_pulse();
        wait_busy("retrig_busy_len", 500);
        tick_n(5);
        check("no_swap_mid_copy", bank, 1);
        sweep("old_bank_sweep", 0);
        LVBL = 1'b1;
        tick();
        vblank();
        check("retrig_bank_swap", bank, 0);
        sweep("retrig_sweep", 2);

        // Pending swap cancelled by a trigger coinciding with vblank start
        trig_pulse();
        wait_busy("pend_busy_len", 0);
        cpu_write(0, 16'h0001, 2'b00);
        LVBL     = 1'b0;
        dma_trig = 1'b1;
        tick();
        dma_trig = 1'b0;
        check("trig_beats_swap_bank", bank, 0);
        check("trig_beats_swap_busy", dma_busy, 1);
        wait_busy("cancel_busy_len", 0);
        tick();
        LVBL = 1'b1;
        tick();
        check("cancel_no_swap_in_vb", bank, 0);
        vblank();
        check("cancel_bank_swap", bank, 1);
        vblank();
        check("cancel_single_toggle", bank, 1);
        tbl_addr = '0;
        tick();
        check("cancel_addr0", tbl_dout, 16'h0001);
        sweep("cancel_sweep", 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
